toeplitz_row_sum: RTL and testbench

- Consumer end of the Toeplitz row generator.
- Loads one ROW_W-bit raw input block, then accepts one generated row per sum_en pulse.
- For each row, computes the hash bit parity(row AND raw) in a two-stage pipeline and packs the bits into OUT_W-bit output words.
- After ROWS_PER_BLOCK rows the raw block is released and the next one is loaded.

---
 rtl/toeplitz_row_sum.sv | 192 +++++++++++++++++++
 tb/tb_toeplitz_row_sum.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toeplitz_row_sum.sv
`default_nettype none
// ============================================================================
// Module : toeplitz_row_sum
// Brief  : Loads a raw block, hashes each Toeplitz row to one parity bit and
//          packs the bits into output words.
// Rev    : 1.0
// ============================================================================
module toeplitz_row_sum #(
    parameter int ROW_W          = 3072,
    parameter int CHUNK_W        = 256,
    parameter int RAW_IN_W       = 32,
    parameter int OUT_W          = 32,
    parameter int ROWS_PER_BLOCK = 1024
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                raw_valid,
    input  logic [RAW_IN_W-1:0] raw_data,
    output logic                raw_ready,
    input  logic                sum_en,
    input  logic [ROW_W-1:0]    row,
    output logic                out_valid,
    output logic [OUT_W-1:0]    out_data,
    input  logic                out_ready,
    output logic                block_done,
    output logic                row_drop,
    output logic                out_ovf
);
    localparam int c_chunks    = ROW_W / CHUNK_W;
    localparam int c_raw_words = ROW_W / RAW_IN_W;
    localparam int c_wcnt_w    = (c_raw_words > 1) ? $clog2(c_raw_words) : 1;
    localparam int c_rcnt_w    = (ROWS_PER_BLOCK > 1) ? $clog2(ROWS_PER_BLOCK) : 1;
    localparam int c_bcnt_w    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [c_wcnt_w-1:0] c_last_word = c_wcnt_w'(c_raw_words - 1);
    localparam logic [c_rcnt_w-1:0] c_last_row  = c_rcnt_w'(ROWS_PER_BLOCK - 1);
    localparam logic [c_bcnt_w-1:0] c_last_bit  = c_bcnt_w'(OUT_W - 1);

    localparam logic [1:0] c_st_load  = 2'd0;
    localparam logic [1:0] c_st_hash  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic                w_accept;
    logic                w_drop;
    logic                w_raw_fire;
    logic                w_last_word;
    logic                w_last_row;
    logic                w_drain_done;
    logic [ROW_W-1:0]    r_raw;
    logic [c_wcnt_w-1:0] r_wcnt;
    logic [c_rcnt_w-1:0] r_rcnt;
    logic [c_chunks-1:0] w_p1;
    logic [c_chunks-1:0] r_p1;
    logic                r_v1;
    logic                r_hbit;
    logic                r_v2;
    logic [OUT_W-1:0]    r_pack;
    logic [c_bcnt_w-1:0] r_bcnt;
    logic                w_word_done;
    logic [OUT_W-1:0]    w_word;
    logic                r_out_valid;
    logic [OUT_W-1:0]    r_out_data;
    logic                r_block_done;
    logic                r_row_drop;
    logic                r_out_ovf;

    assign w_raw_fire   = raw_valid && raw_ready;
    assign w_last_word  = (r_wcnt == c_last_word);
    assign w_last_row   = (r_rcnt == c_last_row);
    // Block ends only once nothing is in flight and the final word is handed off.
    assign w_drain_done = (r_state == c_st_drain) && !r_v1 && !r_v2 &&
                          (r_bcnt == '0) && r_out_valid && out_ready;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_load;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_load:  if (w_raw_fire && w_last_word) w_next_state = c_st_hash;
            c_st_hash:  if (w_accept && w_last_row)    w_next_state = c_st_drain;
            c_st_drain: if (w_drain_done)              w_next_state = c_st_load;
            default:    w_next_state = c_st_load;
        endcase
    end

    always_comb begin
        raw_ready = 1'b0;
        w_accept  = 1'b0;
        w_drop    = 1'b0;
        case (r_state)
            c_st_load: begin
                raw_ready = 1'b1;
                w_drop    = sum_en;
            end
            c_st_hash: w_accept = sum_en;
            default:   w_drop   = sum_en;
        endcase
    end

    genvar k;
    generate
        for (k = 0; k < c_chunks; k++) begin : g_chunk
            assign w_p1[k] = ^(row[k*CHUNK_W +: CHUNK_W] & r_raw[k*CHUNK_W +: CHUNK_W]);
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_raw  <= '0;
            r_wcnt <= '0;
            r_rcnt <= '0;
        end else if (w_drain_done) begin
            r_raw  <= '0;
            r_wcnt <= '0;
            r_rcnt <= '0;
        end else begin
            if (w_raw_fire) begin
                r_raw  <= (r_raw << RAW_IN_W) | ROW_W'(raw_data);
                r_wcnt <= w_last_word ? '0 : r_wcnt + 1'b1;
            end
            if (w_accept) begin
                r_rcnt <= w_last_row ? '0 : r_rcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_p1   <= '0;
            r_v1   <= 1'b0;
            r_hbit <= 1'b0;
            r_v2   <= 1'b0;
        end else begin
            if (w_accept) r_p1 <= w_p1;
            r_v1   <= w_accept;
            r_hbit <= ^r_p1;
            r_v2   <= r_v1;
        end
    end

    assign w_word_done = r_v2 && (r_bcnt == c_last_bit);
    assign w_word      = r_pack | (OUT_W'(r_hbit) << r_bcnt);

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_pack      <= '0;
            r_bcnt      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;
            if (w_word_done) begin
                // A completed word always wins the output register, even over an unread one.
                r_pack      <= '0;
                r_bcnt      <= '0;
                r_out_data  <= w_word;
                r_out_valid <= 1'b1;
                if (r_out_valid && !out_ready) r_out_ovf <= 1'b1;
            end else if (r_v2) begin
                r_pack <= w_word;
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_block_done <= 1'b0;
            r_row_drop   <= 1'b0;
        end else begin
            r_block_done <= w_drain_done;
            if (w_drop) r_row_drop <= 1'b1;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign block_done = r_block_done;
    assign row_drop   = r_row_drop;
    assign out_ovf    = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_toeplitz_row_sum.sv
`default_nettype none
// ============================================================================
// Module : tb_toeplitz_row_sum
// Brief  : Random stimulus against a queue-based behavioural model, plus fixed
//          hand-computed expectations for the directed scenarios.
// Rev    : 1.0
// ============================================================================
module tb_toeplitz_row_sum;
    localparam int ROW_W    = 3072;
    localparam int CHUNK_W  = 256;
    localparam int RAW_IN_W = 32;
    localparam int OUT_W    = 32;
    localparam int RPB      = 64;
    localparam int NW       = ROW_W / RAW_IN_W;

    logic                clk_in    = 1'b0;
    logic                rst       = 1'b1;
    logic                raw_valid = 1'b0;
    logic [RAW_IN_W-1:0] raw_data  = '0;
    logic                sum_en    = 1'b0;
    logic [ROW_W-1:0]    row       = '0;
    logic                out_ready = 1'b0;
    logic                raw_ready;
    logic                out_valid;
    logic [OUT_W-1:0]    out_data;
    logic                block_done;
    logic                row_drop;
    logic                out_ovf;

    toeplitz_row_sum #(
        .ROW_W(ROW_W), .CHUNK_W(CHUNK_W), .RAW_IN_W(RAW_IN_W),
        .OUT_W(OUT_W), .ROWS_PER_BLOCK(RPB)
    ) dut (
        .clk_in(clk_in), .rst(rst), .raw_valid(raw_valid), .raw_data(raw_data),
        .raw_ready(raw_ready), .sum_en(sum_en), .row(row), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .block_done(block_done),
        .row_drop(row_drop), .out_ovf(out_ovf)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int nprint = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int   due;
        logic b;
    } pend_t;

    pend_t            pq[$];
    pend_t            pe;
    int               cyc     = 0;
    int               m_phase = 0;   // 0 load, 1 hash, 2 drain
    int               m_nw    = 0;
    int               m_rows  = 0;
    int               m_bits  = 0;
    logic [ROW_W-1:0] m_raw   = '0;
    logic [OUT_W-1:0] m_word  = '0;
    logic [OUT_W-1:0] m_od    = '0;
    logic             m_ov    = 1'b0;
    logic             m_bd    = 1'b0;
    logic             m_drop  = 1'b0;
    logic             m_ovf   = 1'b0;
    logic             mt, md;

    initial forever begin
        @(posedge clk_in or negedge rst);
        if (!rst) begin
            pq.delete();
            m_phase = 0; m_nw = 0; m_rows = 0; m_bits = 0;
            m_raw = '0; m_word = '0; m_od = '0;
            m_ov = 1'b0; m_bd = 1'b0; m_drop = 1'b0; m_ovf = 1'b0;
        end else begin
            cyc++;
            mt   = m_ov && out_ready;
            md   = (m_phase == 2) && (pq.size() == 0) && (m_bits == 0) && mt;
            m_bd = 1'b0;
            if (sum_en && m_phase != 1) m_drop = 1'b1;
            if (mt) m_ov = 1'b0;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                pe = pq.pop_front();
                m_word[m_bits] = pe.b;
                m_bits++;
                if (m_bits == OUT_W) begin
                    if (m_ov) m_ovf = 1'b1;
                    m_od   = m_word;
                    m_ov   = 1'b1;
                    m_word = '0;
                    m_bits = 0;
                end
            end
            if (sum_en && m_phase == 1) begin
                pe.due = cyc + 2;
                pe.b   = ^(row & m_raw);
                pq.push_back(pe);
                m_rows++;
                if (m_rows == RPB) m_phase = 2;
            end
            if (raw_valid && m_phase == 0) begin
                m_raw = {m_raw[ROW_W-RAW_IN_W-1:0], raw_data};
                m_nw++;
                if (m_nw == NW) begin
                    m_phase = 1;
                    m_nw    = 0;
                end
            end
            if (md) begin
                m_bd = 1'b1; m_phase = 0; m_raw = '0; m_rows = 0;
            end
        end
    end

    // ---------------- per-cycle compare and monitors ----------------
    logic [OUT_W-1:0] taken[$];
    int   bd_cnt  = 0;
    int   ncyc    = 0;
    logic arm_lat = 1'b0;
    int   lat_s   = -1;
    int   lat_o   = -1;

    initial forever begin
        @(negedge clk_in);
        ncyc++;
        if (rst) begin
            checks++;
            if (raw_ready !== (m_phase == 0) || out_valid !== m_ov || out_data !== m_od ||
                block_done !== m_bd || row_drop !== m_drop || out_ovf !== m_ovf) begin
                errors++;
                if (nprint < 20)
                    $display("FAIL cycle_compare t=%0t got rr=%b ov=%b od=%h bd=%b rd=%b of=%b exp rr=%b ov=%b od=%h bd=%b rd=%b of=%b",
                             $time, raw_ready, out_valid, out_data, block_done, row_drop, out_ovf,
                             (m_phase == 0), m_ov, m_od, m_bd, m_drop, m_ovf);
                nprint++;
            end
            if (out_valid && out_ready) taken.push_back(out_data);
            if (block_done) bd_cnt++;
            if (arm_lat && sum_en && lat_s < 0) lat_s = ncyc;
            if (arm_lat && out_valid && lat_s >= 0 && lat_o < 0) lat_o = ncyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [RAW_IN_W-1:0] blk[NW];
    logic [ROW_W-1:0]    blk_vec;
    logic [ROW_W-1:0]    rows_q[$];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0; sum_en = 1'b0; raw_valid = 1'b0;
        repeat (n) tick();
        rst = 1'b1;
    endtask

    task automatic rand_blk();
        for (int i = 0; i < NW; i++) blk[i] = $urandom;
    endtask

    task automatic set_blk_vec();
        for (int i = 0; i < NW; i++) blk_vec[ROW_W-1-RAW_IN_W*i -: RAW_IN_W] = blk[i];
    endtask

    task automatic load_block(input int gap_pct);
        int sent  = 0;
        int guard = 0;
        set_blk_vec();
        while (sent < NW && guard < NW * 20) begin
            raw_valid = ($urandom_range(99) >= gap_pct);
            raw_data  = raw_valid ? blk[sent] : $urandom;
            if (raw_valid && raw_ready) sent++;
            tick();
            guard++;
        end
        raw_valid = 1'b0;
        check("load_words", sent, NW);
    endtask

    function automatic logic [ROW_W-1:0] make_row(input int mode, input int i);
        logic [ROW_W-1:0] r;
        int a, b;
        r = '0;
        case (mode)
            0: r[0] = 1'b1;
            1: begin
                a = int'($urandom_range(ROW_W - 1));
                b = (a + 1 + int'($urandom_range(ROW_W - 2))) % ROW_W;
                r[a] = 1'b1;
                r[b] = 1'b1;
            end
            2: r[ROW_W-1] = (i % 2 == 0);
            default: for (int w = 0; w < ROW_W / 32; w++) r[w*32 +: 32] = $urandom;
        endcase
        return r;
    endfunction

    task automatic send_rows(input int mode, input int n, input int gap_pct, input bit rnd_ready);
        for (int i = 0; i < n; i++) begin
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                sum_en = 1'b0;
                if (rnd_ready) out_ready = $urandom_range(1);
                tick();
            end
            row = make_row(mode, i);
            rows_q.push_back(row);
            sum_en    = 1'b1;
            raw_valid = $urandom_range(1);
            raw_data  = $urandom;
            if (rnd_ready) out_ready = $urandom_range(1);
            tick();
        end
        sum_en    = 1'b0;
        raw_valid = 1'b0;
    endtask

    task automatic wait_bd(input int limit, input bit rnd_ready);
        int start = bd_cnt;
        int n     = 0;
        while (bd_cnt == start && n < limit) begin
            if (rnd_ready) out_ready = $urandom_range(1);
            tick();
            n++;
        end
        check("block_done_seen", bd_cnt - start, 1);
    endtask

    function automatic logic [OUT_W-1:0] exp_word(input int j);
        logic [OUT_W-1:0] w;
        w = '0;
        for (int i = 0; i < OUT_W; i++) w[i] = ^(rows_q[j*OUT_W+i] & blk_vec);
        return w;
    endfunction

    function automatic logic [63:0] tk(input int i);
        if (i < taken.size()) return {32'h0, taken[i]};
        return 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    // ---------------- scenarios ----------------
    initial begin
        #2;
        do_reset(3);
        check("rst_raw_ready", raw_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data, 0);
        check("rst_row_drop",  row_drop, 0);
        check("rst_out_ovf",   out_ovf, 0);

        // all-ones raw: single-bit rows hash to 1, two-bit rows to 0
        out_ready = 1'b1;
        for (int i = 0; i < NW; i++) blk[i] = 32'hFFFF_FFFF;
        load_block(0);
        rows_q.delete(); taken.delete();
        send_rows(0, 32, 0, 1'b0);
        send_rows(1, 32, 0, 1'b0);
        wait_bd(200, 1'b0);
        check("ones_words",   taken.size(), 2);
        check("ones_w0",      tk(0), 64'hFFFF_FFFF);
        check("ones_w1",      tk(1), 64'h0);
        check("ones_raw_rdy", raw_ready, 1);
        check("ones_no_drop", row_drop, 0);

        // single raw bit in the MSB, alternating rows, one extra pulse past the block
        for (int i = 0; i < NW; i++) blk[i] = '0;
        blk[0] = 32'h8000_0000;
        load_block(0);
        rows_q.delete(); taken.delete();
        lat_s = -1; lat_o = -1; arm_lat = 1'b1;
        send_rows(2, RPB + 1, 0, 1'b0);
        wait_bd(200, 1'b0);
        arm_lat = 1'b0;
        check("lat_first_word", lat_o - lat_s, 34);
        check("alt_words",      taken.size(), 2);
        check("alt_w0",         tk(0), 64'h5555_5555);
        check("alt_w1",         tk(1), 64'h5555_5555);
        check("extra_row_drop", row_drop, 1);
        check("alt_raw_rdy",    raw_ready, 1);

        // backpressure across both words of a block
        rand_blk();
        load_block(20);
        check("pre_ovf", out_ovf, 0);
        out_ready = 1'b0;
        rows_q.delete(); taken.delete();
        send_rows(3, RPB, 0, 1'b0);
        repeat (6) tick();
        check("bp_out_valid", out_valid, 1);
        check("bp_out_ovf",   out_ovf, 1);
        check("bp_out_data",  out_data, exp_word(1));
        out_ready = 1'b1;
        wait_bd(50, 1'b0);
        check("bp_words", taken.size(), 1);
        check("bp_taken", tk(0), exp_word(1));

        // reset in the middle of a block, then a clean block
        rand_blk();
        load_block(0);
        rows_q.delete(); taken.delete();
        send_rows(3, 10, 0, 1'b0);
        do_reset(3);
        check("mid_out_valid", out_valid, 0);
        check("mid_out_data",  out_data, 0);
        check("mid_raw_ready", raw_ready, 1);
        check("mid_ovf_clr",   out_ovf, 0);
        check("mid_drop_clr",  row_drop, 0);
        check("mid_no_words",  taken.size(), 0);
        rand_blk();
        load_block(30);
        rows_q.delete(); taken.delete();
        send_rows(3, RPB, 30, 1'b0);
        wait_bd(400, 1'b0);
        check("post_words", taken.size(), 2);
        check("post_w0",    tk(0), exp_word(0));
        check("post_w1",    tk(1), exp_word(1));

        // random blocks with random gaps and random downstream readiness
        for (int b = 0; b < 2; b++) begin
            rand_blk();
            load_block(25);
            send_rows(3, RPB, 25, 1'b1);
            wait_bd(600, 1'b1);
        end
        check("load_drop_pre", row_drop, 0);
        sum_en = 1'b1;
        tick();
        sum_en = 1'b0;
        check("load_drop", row_drop, 1);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
